// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core, debug) for a single data-memory port.
// Core has priority with bounded debug starvation; debug may lock the port.
module dmem_arbiter #(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic          dbg_lock,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   typedef enum logic {SHARED = 1'b0, DBG_LOCKED = 1'b1} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [WCW-1:0] r_wait_cnt;
   logic [WCW-1:0] w_wait_nxt;
   logic           w_locked;
   logic           w_core_win;
   logic           w_dbg_win;
   logic           r_core_rvalid;
   logic           r_dbg_rvalid;
   logic [DW-1:0]  r_core_rdata;
   logic [DW-1:0]  r_dbg_rdata;

   // Lock is sampled live, so dropping it hands the port back in the same cycle.
   assign w_locked = (r_state == DBG_LOCKED) && dbg_lock;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= SHARED;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Arbitration, lock tracking and starvation counter.
   always_comb begin
      w_core_win  = 1'b0;
      w_dbg_win   = 1'b0;
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      if (!RST_N) begin
         w_core_win = 1'b0;
         w_dbg_win  = 1'b0;
      end else if (w_locked) begin
         w_dbg_win = dbg_req;
      end else if (core_req && dbg_req) begin
         if (r_wait_cnt == WAIT_MAX) w_dbg_win  = 1'b1;
         else                        w_core_win = 1'b1;
      end else begin
         w_core_win = core_req;
         w_dbg_win  = dbg_req;
      end

      if (dbg_lock && (w_locked || w_dbg_win)) w_state_nxt = DBG_LOCKED;
      else                                      w_state_nxt = SHARED;

      if (w_locked || w_dbg_win)                     w_wait_nxt = '0;
      else if (dbg_req && (r_wait_cnt != WAIT_MAX))  w_wait_nxt = r_wait_cnt + WCW'(1);
   end

   assign core_gnt  = w_core_win;
   assign dbg_gnt   = w_dbg_win;
   assign mem_we    = (w_core_win & core_we) | (w_dbg_win & dbg_we);
   assign mem_addr  = w_dbg_win ? dbg_addr  : core_addr;
   assign mem_wdata = w_dbg_win ? dbg_wdata : core_wdata;

   // Read return path: one-cycle latency, data held between pulses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_core_rvalid <= 1'b0;
         r_dbg_rvalid  <= 1'b0;
         r_core_rdata  <= '0;
         r_dbg_rdata   <= '0;
      end else begin
         r_core_rvalid <= w_core_win & ~core_we;
         r_dbg_rvalid  <= w_dbg_win & ~dbg_we;
         if (w_core_win && !core_we) r_core_rdata <= mem_rdata;
         if (w_dbg_win && !dbg_we)   r_dbg_rdata  <= mem_rdata;
      end
   end

   assign core_rvalid = r_core_rvalid;
   assign core_rdata  = r_core_rdata;
   assign dbg_rvalid  = r_dbg_rvalid;
   assign dbg_rdata   = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: explicit grant expectations per cycle,
// read data checked through per-requester scoreboard queues.
module tb_dmem_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          core_req, core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          core_gnt, core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          dbg_req, dbg_we, dbg_lock;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem   [0:255];
   logic [DW-1:0] model [0:255];
   logic [DW-1:0] q_core[$];
   logic [DW-1:0] q_dbg[$];
   logic          exp_crv, exp_drv;
   int            vectors = 0;
   int            errors  = 0;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
      .core_rdata(core_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Data memory: combinational read, clocked write.
   assign mem_rdata = mem[mem_addr];
   always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pop(input string tag, input logic [DW-1:0] obs, input bit is_core);
      logic [DW-1:0] e;
      if (is_core ? (q_core.size() == 0) : (q_dbg.size() == 0)) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = is_core ? q_core.pop_front() : q_dbg.pop_front();
         chk(tag, 32'(obs), 32'(e));
      end
   endtask

   // One clock cycle with inputs already applied; ec/ed are the expected grants.
   task automatic cyc(input string tag, input logic ec, input logic ed);
      @(negedge CLK);
      chk({tag, "_crv"}, 32'(core_rvalid), 32'(exp_crv));
      if (exp_crv) chk_pop({tag, "_crdata"}, core_rdata, 1'b1);
      chk({tag, "_drv"}, 32'(dbg_rvalid), 32'(exp_drv));
      if (exp_drv) chk_pop({tag, "_drdata"}, dbg_rdata, 1'b0);
      chk({tag, "_cgnt"}, 32'(core_gnt), 32'(ec));
      chk({tag, "_dgnt"}, 32'(dbg_gnt), 32'(ed));
      chk({tag, "_mwe"}, 32'(mem_we), 32'((ec & core_we) | (ed & dbg_we)));
      exp_crv = ec & ~core_we;
      exp_drv = ed & ~dbg_we;
      if (exp_crv) q_core.push_back(model[core_addr]);
      if (exp_drv) q_dbg.push_back(model[dbg_addr]);
      if (ec && core_we) model[core_addr] = core_wdata;
      if (ed && dbg_we)  model[dbg_addr]  = dbg_wdata;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      core_req = req; core_we = we; core_addr = a; core_wdata = d;
   endtask

   task automatic set_dbg(input logic req, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_req = req; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 8'(i * 7 + 3);
         model[i] = 8'(i * 7 + 3);
      end
      mem[10] = 8'h5A; model[10] = 8'h5A;
      exp_crv = 1'b0; exp_drv = 1'b0;
      RST_N = 1'b0;
      set_core(1'b1, 1'b1, 8'd9, 8'hEE);
      set_dbg(1'b1, 1'b1, 1'b0, 8'd8, 8'hDD);

      // Held in reset with writes requested: nothing granted, nothing written.
      @(negedge CLK);
      chk("rst_cgnt", 32'(core_gnt), 32'd0);
      chk("rst_dgnt", 32'(dbg_gnt), 32'd0);
      chk("rst_mwe", 32'(mem_we), 32'd0);
      chk("rst_crv", 32'(core_rvalid), 32'd0);
      chk("rst_drv", 32'(dbg_rvalid), 32'd0);
      chk("rst_crdata", 32'(core_rdata), 32'd0);
      chk("rst_drdata", 32'(dbg_rdata), 32'd0);
      @(posedge CLK); #1;
      chk("rst_mem9", 32'(mem[9]), 32'(model[9]));
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      set_dbg(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      RST_N = 1'b1;
      cyc("idle0", 1'b0, 1'b0);

      // Core read, no conflict.
      set_core(1'b1, 1'b0, 8'd10, 8'd0);
      cyc("c_rd", 1'b1, 1'b0);
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      cyc("c_rd_ret", 1'b0, 1'b0);

      // Back-to-back writes from both requesters.
      set_core(1'b1, 1'b1, 8'd0, 8'h01);
      cyc("c_wr", 1'b1, 1'b0);
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      set_dbg(1'b1, 1'b1, 1'b0, 8'd1, 8'h02);
      cyc("d_wr", 1'b0, 1'b1);
      set_dbg(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      cyc("wr_idle", 1'b0, 1'b0);
      chk("mem0", 32'(mem[0]), 32'h01);
      chk("mem1", 32'(mem[1]), 32'h02);

      // Sustained conflict: debug wins every fifth cycle.
      set_core(1'b1, 1'b0, 8'd20, 8'd0);
      set_dbg(1'b1, 1'b0, 1'b0, 8'd30, 8'd0);
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("conf%0d", i), (i % 5) != 4, (i % 5) == 4);
      end
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      set_dbg(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      cyc("conf_idle", 1'b0, 1'b0);

      // Locked debug write; core shut out until lock drops.
      set_dbg(1'b1, 1'b1, 1'b1, 8'd3, 8'h11);
      cyc("lk_wr", 1'b0, 1'b1);
      set_core(1'b1, 1'b0, 8'd3, 8'd0);
      set_dbg(1'b1, 1'b0, 1'b1, 8'd3, 8'd0);
      cyc("lk_rd", 1'b0, 1'b1);
      set_dbg(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
      cyc("lk_hold", 1'b0, 1'b0);
      set_dbg(1'b1, 1'b0, 1'b0, 8'd4, 8'd0);
      cyc("lk_exit", 1'b1, 1'b0);
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      set_dbg(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      cyc("lk_idle", 1'b0, 1'b0);
      chk("mem3", 32'(mem[3]), 32'h11);

      // Reset lands between a locked debug read grant and its return.
      set_dbg(1'b1, 1'b0, 1'b1, 8'd7, 8'd0);
      @(negedge CLK);
      chk("mr_dgnt", 32'(dbg_gnt), 32'd1);
      #2;
      RST_N = 1'b0;
      set_core(1'b1, 1'b1, 8'd12, 8'h77);
      set_dbg(1'b1, 1'b1, 1'b1, 8'd13, 8'h66);
      #1;
      chk("mr_cgnt", 32'(core_gnt), 32'd0);
      chk("mr_dgnt0", 32'(dbg_gnt), 32'd0);
      chk("mr_mwe", 32'(mem_we), 32'd0);
      chk("mr_drdata", 32'(dbg_rdata), 32'd0);
      @(posedge CLK); #1;
      chk("mr_drv", 32'(dbg_rvalid), 32'd0);
      chk("mr_drdata1", 32'(dbg_rdata), 32'd0);
      chk("mr_mwe1", 32'(mem_we), 32'd0);
      chk("mr_mem12", 32'(mem[12]), 32'(model[12]));
      q_core.delete(); q_dbg.delete();
      exp_crv = 1'b0; exp_drv = 1'b0;
      // Back in SHARED: core wins a conflict even with lock asserted.
      set_core(1'b1, 1'b0, 8'd12, 8'd0);
      set_dbg(1'b1, 1'b0, 1'b1, 8'd13, 8'd0);
      RST_N = 1'b1;
      cyc("post_rst", 1'b1, 1'b0);
      set_core(1'b0, 1'b0, 8'd0, 8'd0);
      set_dbg(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      cyc("post_idle", 1'b0, 1'b0);
      cyc("end_idle", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
